vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset: `CLK` (input, 1 bit, pixel clock, 25 MHz nominal) and `CLR_N` (input, 1 bit, asynchronous active-low reset).
REQ-002 SHALL have the following data ports:
  - `HSYNC`: input, 1 bit, horizontal sync, active-low, synchronous to `CLK`.
  - `VSYNC`: input, 1 bit, vertical sync, active-low, synchronous to `CLK`.
  - `ERR_CLR`: input, 1 bit; a 1-cycle pulse clears `ERR`.
  - `HC`: output, 10 bits, recovered horizontal pixel count.
  - `VC`: output, 10 bits, recovered line count.
  - `VIDON`: output, 1 bit, recovered active-video window.
  - `LOCKED`: output, 1 bit, the decoder is locked to a valid 640x480 frame.
  - `ERR`: output, 4 bits, sticky error flags: [0] line length, [1] hsync width, [2] frame length, [3] vsync width.
  - `ERR_PULSE`: output, 1 bit, 1-cycle pulse on any new error event.

Function
REQ-003 SHALL register `HSYNC` and `VSYNC` into `hs_q` and `vs_q` every `CLK` edge.
  - A fall is input 0 with `q` = 1; a rise is input 1 with `q` = 0.
REQ-004 On an `HSYNC` fall, `HC` SHALL load 0; otherwise `HC` SHALL increment, saturating at 1023.
REQ-005 A `VSYNC` fall SHALL set the `vpend` flag.
REQ-006 On an `HSYNC` fall with `vpend` set, or with a `VSYNC` fall in the same cycle, `VC` SHALL load 0 and `vpend` SHALL clear (frame start).
  - On any other `HSYNC` fall, `VC` SHALL increment, saturating at 1023.
  - `VC` SHALL hold between `HSYNC` falls.
REQ-007 For a conforming source, `HC` and `VC` SHALL equal the source's counters delayed by exactly 1 `CLK`.
REQ-008 `VIDON` SHALL be combinational: `LOCKED` and 144 <= `HC` < 784 and 31 <= `VC` < 511.
REQ-009 Checks SHALL be active only in states `VERIFY` and `LOCKED`, and SHALL use the pre-update `HC`/`VC`:
  - `HSYNC` fall with `HC` != 799 -> `ERR[0]`.
  - `HSYNC` rise with `HC` != 127 -> `ERR[1]`.
  - Frame start with `VC` != 520 -> `ERR[2]`.
  - `VSYNC` rise coincident with an `HSYNC` fall, with `VC` != 1 -> `ERR[3]`.
  - `HC` reaching 1023 -> `ERR[0]` (line timeout).
  - `VC` reaching 1023 -> `ERR[2]` (frame timeout).
REQ-010 An error event SHALL set its `ERR` bit and assert `ERR_PULSE` in the cycle after the violating sample.
  - If `ERR_CLR` and a new event occur in the same cycle, the set SHALL take priority.
REQ-011 The lock FSM SHALL have three states: `SEARCH`, `VERIFY`, `LOCKED`.
  - `SEARCH` -> `VERIFY` on a frame start.
  - `VERIFY` -> `LOCKED` on the next frame start if no error occurred since entry.
  - `VERIFY` or `LOCKED` -> `SEARCH` on any error event.
  - An error and a frame start in the same cycle SHALL go to `SEARCH`.
REQ-012 `LOCKED` SHALL be 1 exactly when the FSM is in state `LOCKED`; the output SHALL be registered.

Reset
REQ-013 With `CLR_N` = 0, the block SHALL hold the following values regardless of `CLK`:
  - `HC` = 0, `VC` = 0, `hs_q` = 0, `vs_q` = 0, `vpend` = 0.
  - FSM = `SEARCH`, `LOCKED` = 0, `VIDON` = 0, `ERR` = 0, `ERR_PULSE` = 0.
REQ-014 After reset release, a sync input already low SHALL NOT produce a fall; a genuine high-to-low transition is required.
REQ-015 Reset asserted mid-frame SHALL discard lock; re-lock SHALL require two frame starts.

Structure
REQ-016 Package `vga_pkg` SHALL hold the shared timing constants and the FSM state enum type.
  - Timing constants: `HPIXELS`=800, `VLINES`=521, `HSW`=128, `VSW`=2, `HBP`=144, `HFP`=784, `VBP`=31, `VFP`=511.
REQ-017 Sub-module `vga_edge_det` (registers a sync, outputs rise/fall) SHALL be instantiated once per sync input.

Verification
REQ-018 A conforming 800x521 source, started from reset, SHALL produce:
  - `LOCKED` = 1 one cycle after the second frame start.
  - `HC`/`VC` equal to the source counters delayed by 1 cycle thereafter.
  - `ERR` = 0.
REQ-019 A locked decoder fed one line of 801 clocks SHALL show:
  - `ERR[0]` = 1 and an `ERR_PULSE`.
  - `LOCKED` = 0 on the next cycle.
  - Re-lock after two clean frame starts.
REQ-020 A locked decoder fed a 127-clock `HSYNC` pulse SHALL show `ERR[1]` = 1 and `LOCKED` = 0.
  - A 3-line `VSYNC` pulse SHALL give `ERR[3]` = 1.
  - A 522-line frame SHALL give `ERR[2]` = 1.
REQ-021 With `HSYNC` stuck high for 1100 clocks while locked:
  - `HC` SHALL saturate at 1023.
  - `ERR[0]` SHALL set and `LOCKED` SHALL drop.
REQ-022 `CLR_N` pulsed low mid-frame SHALL give all outputs 0 immediately, asynchronously.
  - Re-lock SHALL follow the second frame start after release.
  - `ERR_CLR` with no new event SHALL clear `ERR` to 0 on the next cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants and lock-state type for the sync decoder.
package vga_pkg;

  localparam int unsigned HPIXELS = 800;
  localparam int unsigned VLINES  = 521;
  localparam int unsigned HSW     = 128;
  localparam int unsigned VSW     = 2;
  localparam int unsigned HBP     = 144;
  localparam int unsigned HFP     = 784;
  localparam int unsigned VBP     = 31;
  localparam int unsigned VFP     = 511;

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    StSearch,
    StVerify,
    StLocked
  } lock_state_e;

endpackage

// File: rtl/vga_edge_det.sv
// Registers one active-low sync input and flags its rising and falling edges.
module vga_edge_det (
  input  logic CLK,
  input  logic CLR_N,
  input  logic SYNC,
  output logic RISE,
  output logic FALL
);

  logic sync_q;

  // Resetting to 0 means a sync already low at release never looks like a fall.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= SYNC;
    end
  end

  assign FALL = ~SYNC & sync_q;
  assign RISE = SYNC & ~sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line counters from HSYNC/VSYNC, checks 640x480 timing and tracks lock.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL     = HPIXELS,
  parameter int unsigned H_SYNC      = HSW,
  parameter int unsigned H_VID_START = HBP,
  parameter int unsigned H_VID_END   = HFP,
  parameter int unsigned V_TOTAL     = VLINES,
  parameter int unsigned V_SYNC      = VSW,
  parameter int unsigned V_VID_START = VBP,
  parameter int unsigned V_VID_END   = VFP
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             HSYNC,
  input  logic             VSYNC,
  input  logic             ERR_CLR,
  output logic [CNT_W-1:0] HC,
  output logic [CNT_W-1:0] VC,
  output logic             VIDON,
  output logic             LOCKED,
  output logic [3:0]       ERR,
  output logic             ERR_PULSE
);

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SW_LAST = CNT_W'(H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_SW_LAST = CNT_W'(V_SYNC - 1);
  localparam logic [CNT_W-1:0] H_VS      = CNT_W'(H_VID_START);
  localparam logic [CNT_W-1:0] H_VE      = CNT_W'(H_VID_END);
  localparam logic [CNT_W-1:0] V_VS      = CNT_W'(V_VID_START);
  localparam logic [CNT_W-1:0] V_VE      = CNT_W'(V_VID_END);

  logic             hs_rise, hs_fall, vs_rise, vs_fall;
  logic [CNT_W-1:0] hc_q, vc_q;
  logic             vpend_q;
  lock_state_e      state_q;
  logic             locked_q;
  logic [3:0]       err_q;
  logic             err_pulse_q;
  logic             frame_start;
  logic             checks_on;
  logic [3:0]       ev;

  vga_edge_det u_hs_edge (
    .CLK  (CLK),
    .CLR_N(CLR_N),
    .SYNC (HSYNC),
    .RISE (hs_rise),
    .FALL (hs_fall)
  );

  vga_edge_det u_vs_edge (
    .CLK  (CLK),
    .CLR_N(CLR_N),
    .SYNC (VSYNC),
    .RISE (vs_rise),
    .FALL (vs_fall)
  );

  assign frame_start = hs_fall & (vpend_q | vs_fall);
  assign checks_on   = (state_q != StSearch);

  // All checks look at the counters before this cycle's update.
  always_comb begin
    ev = '0;
    if (checks_on) begin
      ev[0] = (hs_fall && (hc_q != H_LAST)) || (hc_q == CNT_MAX);
      ev[1] = hs_rise && (hc_q != H_SW_LAST);
      ev[2] = (frame_start && (vc_q != V_LAST)) || (vc_q == CNT_MAX);
      ev[3] = vs_rise && hs_fall && (vc_q != V_SW_LAST);
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      hc_q        <= '0;
      vc_q        <= '0;
      vpend_q     <= 1'b0;
      err_q       <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      if (hs_fall) begin
        hc_q <= '0;
      end else if (hc_q != CNT_MAX) begin
        hc_q <= hc_q + CNT_W'(1);
      end

      if (frame_start) begin
        vc_q    <= '0;
        vpend_q <= 1'b0;
      end else begin
        if (vs_fall) begin
          vpend_q <= 1'b1;
        end
        if (hs_fall && (vc_q != CNT_MAX)) begin
          vc_q <= vc_q + CNT_W'(1);
        end
      end

      // A new event wins over a simultaneous clear.
      err_q       <= (err_q & ~{4{ERR_CLR}}) | ev;
      err_pulse_q <= |ev;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q  <= StSearch;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        StSearch: begin
          if (frame_start) begin
            state_q <= StVerify;
          end
        end
        StVerify: begin
          if (|ev) begin
            state_q <= StSearch;
          end else if (frame_start) begin
            state_q  <= StLocked;
            locked_q <= 1'b1;
          end
        end
        StLocked: begin
          if (|ev) begin
            state_q  <= StSearch;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StSearch;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign HC        = hc_q;
  assign VC        = vc_q;
  assign LOCKED    = locked_q;
  assign ERR       = err_q;
  assign ERR_PULSE = err_pulse_q;
  assign VIDON     = locked_q && (hc_q >= H_VS) && (hc_q < H_VE) && (vc_q >= V_VS) && (vc_q < V_VE);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: a shortened-timing instance for whole-frame lock behaviour, plus a
// default-timing instance for line-level checks.
module tb_vga_sync_decoder;

  localparam int HT = 40;
  localparam int HW = 6;
  localparam int VT = 10;
  localparam int VW = 2;
  localparam int HB = 10;
  localparam int HF = 34;
  localparam int VB = 3;
  localparam int VF = 8;

  logic       clk = 1'b0;
  logic       clr_n, hsync, vsync, hs2, vs2, err_clr;
  logic [9:0] hc, vc, hc2, vc2;
  logic       vidon, locked, err_pulse, vidon2, locked2, err_pulse2;
  logic [3:0] err, err2;

  int n_chk   = 0;
  int n_bad   = 0;
  int pulses  = 0;
  int trk_bad = 0;
  int vid_cnt = 0;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_TOTAL    (HT),
    .H_SYNC     (HW),
    .H_VID_START(HB),
    .H_VID_END  (HF),
    .V_TOTAL    (VT),
    .V_SYNC     (VW),
    .V_VID_START(VB),
    .V_VID_END  (VF)
  ) u_dut (
    .CLK      (clk),
    .CLR_N    (clr_n),
    .HSYNC    (hsync),
    .VSYNC    (vsync),
    .ERR_CLR  (err_clr),
    .HC       (hc),
    .VC       (vc),
    .VIDON    (vidon),
    .LOCKED   (locked),
    .ERR      (err),
    .ERR_PULSE(err_pulse)
  );

  vga_sync_decoder u_dflt (
    .CLK      (clk),
    .CLR_N    (clr_n),
    .HSYNC    (hs2),
    .VSYNC    (vs2),
    .ERR_CLR  (err_clr),
    .HC       (hc2),
    .VC       (vc2),
    .VIDON    (vidon2),
    .LOCKED   (locked2),
    .ERR      (err2),
    .ERR_PULSE(err_pulse2)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (err_pulse) pulses++;
  endtask

  task automatic step(input logic h, input logic v);
    hsync = h;
    vsync = v;
    tick();
  endtask

  task automatic send_line(input int from, input int to, input int hsw, input bit vlow,
                           input int line, input bit track);
    logic exp_vid;
    for (int i = from; i < to; i++) begin
      hsync = (i < hsw) ? 1'b0 : 1'b1;
      vsync = vlow ? 1'b0 : 1'b1;
      tick();
      if (track) begin
        if (int'(hc) != i || int'(vc) != line) trk_bad++;
        exp_vid = (i >= HB && i < HF && line >= VB && line < VF);
        if (vidon != exp_vid) trk_bad++;
        if (vidon) vid_cnt++;
      end
    end
  endtask

  task automatic send_lines(input int l0, input int l1, input int vsw, input bit track);
    for (int l = l0; l < l1; l++) send_line(0, HT, HW, l < vsw, l, track);
  endtask

  task automatic dline(input int len, input int hsw, input bit vlow);
    for (int i = 0; i < len; i++) begin
      hs2 = (i < hsw) ? 1'b0 : 1'b1;
      vs2 = vlow ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    clr_n   = 1'b0;
    hsync   = 1'b1;
    vsync   = 1'b1;
    hs2     = 1'b1;
    vs2     = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hc", int'(hc), 0);
    check_eq("rst_vc", int'(vc), 0);
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_err", int'(err), 0);

    // Syncs already low at release must not register as falls.
    hsync = 1'b0;
    vsync = 1'b0;
    clr_n = 1'b1;
    repeat (5) step(1'b0, 1'b0);
    check_eq("no_fall_after_rst", int'(hc), 5);
    repeat (3) step(1'b1, 1'b1);

    send_lines(0, VT, VW, 1'b0);
    check_eq("verify_not_locked", int'(locked), 0);
    step(1'b0, 1'b0);
    check_eq("lock_after_2nd_fs", int'(locked), 1);
    check_eq("fs_hc", int'(hc), 0);
    check_eq("fs_vc", int'(vc), 0);
    pulses = 0;
    send_line(1, HT, HW, 1'b1, 0, 1'b1);
    send_lines(1, VT, VW, 1'b1);
    check_eq("track_hc_vc_vidon", trk_bad, 0);
    check_eq("vidon_count", vid_cnt, (HF - HB) * (VF - VB));
    check_eq("clean_err", int'(err), 0);
    check_eq("clean_pulses", pulses, 0);

    // One line one clock too long.
    send_lines(0, 3, VW, 1'b0);
    send_line(0, HT + 1, HW, 1'b0, 3, 1'b0);
    step(1'b0, 1'b1);
    check_eq("len_err", int'(err), 4'b0001);
    check_eq("len_pulse", int'(err_pulse), 1);
    check_eq("len_unlock", int'(locked), 0);
    step(1'b0, 1'b1);
    check_eq("pulse_one_cycle", int'(err_pulse), 0);
    send_line(2, HT, HW, 1'b0, 4, 1'b0);
    send_lines(5, VT, VW, 1'b0);
    send_lines(0, VT, VW, 1'b0);
    check_eq("one_fs_no_lock", int'(locked), 0);
    step(1'b0, 1'b0);
    check_eq("relock_len", int'(locked), 1);
    err_clr = 1'b1;
    step(1'b0, 1'b0);
    err_clr = 1'b0;
    check_eq("err_clr", int'(err), 0);
    send_line(2, HT, HW, 1'b1, 0, 1'b0);
    send_lines(1, VT, VW, 1'b0);

    // Short hsync pulse, with a coincident clear request.
    send_line(0, HT, HW, 1'b1, 0, 1'b0);
    send_line(0, HW - 1, HW - 1, 1'b1, 1, 1'b0);
    err_clr = 1'b1;
    step(1'b1, 1'b0);
    err_clr = 1'b0;
    check_eq("hsw_err_set_wins", int'(err), 4'b0010);
    check_eq("hsw_unlock", int'(locked), 0);
    send_line(HW, HT, HW, 1'b1, 1, 1'b0);
    send_lines(2, VT, VW, 1'b0);

    // Three-line vsync pulse.
    send_lines(0, VT, VW, 1'b0);
    pulses = 0;
    send_lines(0, VT, 3, 1'b0);
    check_eq("vsw_err", int'(err), 4'b1010);
    check_eq("vsw_pulse", pulses, 1);
    check_eq("vsw_unlock", int'(locked), 0);

    // Frame one line too long.
    err_clr = 1'b1;
    send_lines(0, VT, VW, 1'b0);
    err_clr = 1'b0;
    check_eq("err_clr_hold", int'(err), 0);
    send_lines(0, VT + 1, VW, 1'b0);
    check_eq("lock_before_long", int'(locked), 1);
    step(1'b0, 1'b0);
    check_eq("frame_len_err", int'(err), 4'b0100);
    check_eq("frame_len_unlock", int'(locked), 0);
    send_line(1, HT, HW, 1'b1, 0, 1'b0);
    send_lines(1, VT, VW, 1'b0);

    // Hsync stuck high.
    err_clr = 1'b1;
    send_lines(0, VT, VW, 1'b0);
    send_lines(0, VT, VW, 1'b0);
    err_clr = 1'b0;
    check_eq("lock_before_stuck", int'(locked), 1);
    send_line(0, HW, HW, 1'b1, 0, 1'b0);
    pulses = 0;
    repeat (1100) step(1'b1, 1'b1);
    check_eq("hc_sat", int'(hc), 1023);
    check_eq("stuck_err", int'(err), 4'b0001);
    check_eq("stuck_unlock", int'(locked), 0);
    check_eq("stuck_pulse", pulses, 1);

    // Asynchronous reset mid-frame.
    send_lines(0, VT, VW, 1'b0);
    send_lines(0, VT, VW, 1'b0);
    send_lines(0, 4, VW, 1'b0);
    send_line(0, 20, HW, 1'b0, 4, 1'b0);
    check_eq("vidon_mid", int'(vidon), 1);
    check_eq("err_sticky", int'(err), 4'b0001);
    #3;
    clr_n = 1'b0;
    #1;
    check_eq("arst_hc", int'(hc), 0);
    check_eq("arst_vc", int'(vc), 0);
    check_eq("arst_locked", int'(locked), 0);
    check_eq("arst_vidon", int'(vidon), 0);
    check_eq("arst_err", int'(err), 0);
    check_eq("arst_pulse", int'(err_pulse), 0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    send_line(20, HT, HW, 1'b0, 4, 1'b0);
    send_lines(5, VT, VW, 1'b0);
    send_lines(0, VT, VW, 1'b0);
    check_eq("arst_one_fs", int'(locked), 0);
    step(1'b0, 1'b0);
    check_eq("relock_after_rst", int'(locked), 1);

    // Default 800x521 timing: line-level checks while verifying.
    dline(800, 128, 1'b1);
    dline(800, 128, 1'b1);
    dline(800, 128, 1'b0);
    check_eq("dflt_hc_end", int'(hc2), 799);
    check_eq("dflt_vc", int'(vc2), 2);
    check_eq("dflt_clean", int'(err2), 0);
    dline(800, 127, 1'b0);
    check_eq("dflt_hsw", int'(err2), 4'b0010);
    dline(800, 128, 1'b1);
    dline(801, 128, 1'b1);
    dline(800, 128, 1'b0);
    check_eq("dflt_len", int'(err2), 4'b0011);
    dline(800, 128, 1'b1);
    dline(800, 128, 1'b1);
    dline(800, 128, 1'b1);
    dline(800, 128, 1'b0);
    check_eq("dflt_vsw", int'(err2), 4'b1011);
    check_eq("dflt_unlocked", int'(locked2), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
